// File: rtl/imm_extender_if.sv
// Instruction-in / immediate-out bundle for the RV32I immediate generator.
// The master drives the instruction; the slave returns combinational and registered results.
interface imm_extender_if;
  logic [31:0] instruction;
  logic        valid_in;
  logic [31:0] immediate;
  logic [2:0]  imm_type;
  logic [31:0] immediate_q;
  logic [2:0]  imm_type_q;
  logic        valid_q;

  modport master (
    output instruction, valid_in,
    input  immediate, imm_type, immediate_q, imm_type_q, valid_q
  );

  modport slave (
    input  instruction, valid_in,
    output immediate, imm_type, immediate_q, imm_type_q, valid_q
  );
endinterface

// File: rtl/imm_extender.sv
// RV32I immediate generator: combinational result at zero latency, registered copy one cycle later.
// No backpressure: accepts one instruction per cycle; the registered copy holds while valid_in is low.
module imm_extender (
  input  logic      clk,
  input  logic      rst,
  imm_extender_if.slave bus
);
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_t;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [31:0] imm;
  } imm_rec_t;

  logic [31:0] ins;
  logic        s;
  fmt_t        fmt;
  logic [31:0] imm;
  imm_rec_t    rec_q;
  logic        vld_q;

  assign ins = bus.instruction;
  assign s   = ins[31];

  always_comb begin
    fmt = FMT_NONE;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: fmt = FMT_I;
      7'b0100011:                         fmt = FMT_S;
      7'b1100011:                         fmt = FMT_B;
      7'b0110111, 7'b0010111:             fmt = FMT_U;
      7'b1101111:                         fmt = FMT_J;
      default:                            fmt = FMT_NONE;
    endcase
  end

  // Shift-immediate forms are deliberately not special-cased; the ALU takes the low 5 bits.
  always_comb begin
    imm = 32'h0000_0000;
    case (fmt)
      FMT_I:   imm = {{20{s}}, ins[31:20]};
      FMT_S:   imm = {{20{s}}, ins[31:25], ins[11:7]};
      FMT_B:   imm = {{19{s}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm = {ins[31:12], 12'b0};
      FMT_J:   imm = {{11{s}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
  end

  assign bus.immediate = imm;
  assign bus.imm_type  = fmt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.valid_in;
      if (bus.valid_in) begin
        rec_q.fmt <= fmt;
        rec_q.imm <= imm;
      end
    end
  end

  assign bus.immediate_q = rec_q.imm;
  assign bus.imm_type_q  = rec_q.fmt;
  assign bus.valid_q     = vld_q;
endmodule

// File: tb/tb_imm_extender.sv
// Bench for imm_extender: directed vectors plus random instructions against an arithmetic model.
module tb_imm_extender;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  imm_extender_if bus ();

  imm_extender dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Format code derived from the opcode table of the ISA.
  function automatic logic [2:0] ref_type(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    if (op == 7'h03 || op == 7'h13 || op == 7'h67) return 3'd1;
    if (op == 7'h23) return 3'd2;
    if (op == 7'h63) return 3'd3;
    if (op == 7'h37 || op == 7'h17) return 3'd4;
    if (op == 7'h6F) return 3'd5;
    return 3'd0;
  endfunction

  // Immediate computed as a signed integer offset, then wrapped to 32 bits.
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    longint v;
    v = 0;
    case (ref_type(i))
      3'd1: begin
        v = longint'(i[31:20]);
        if (v >= 2048) v = v - 4096;
      end
      3'd2: begin
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (v >= 2048) v = v - 4096;
      end
      3'd3: begin
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048
          + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
      end
      3'd4: v = longint'(i[31:12]) * 4096;
      3'd5: begin
        v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
          + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (v >= 1048576) v = v - 2097152;
      end
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag, input logic [31:0] ins,
                            input logic [31:0] exp_imm, input logic [2:0] exp_type);
    bus.instruction = ins;
    #1;
    check({tag, "_imm"}, bus.immediate, exp_imm);
    check({tag, "_type"}, {29'd0, bus.imm_type}, {29'd0, exp_type});
  endtask

  task automatic check_regs(input string tag, input logic [31:0] e_imm,
                            input logic [2:0] e_type, input logic e_vld);
    check({tag, "_imm_q"}, bus.immediate_q, e_imm);
    check({tag, "_type_q"}, {29'd0, bus.imm_type_q}, {29'd0, e_type});
    check({tag, "_valid_q"}, {31'd0, bus.valid_q}, {31'd0, e_vld});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12];
    logic [31:0] r;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
            7'h17, 7'h6F, 7'h33, 7'h73, 7'h0F, 7'h7F};
    r = $urandom();
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 11)];
    return r;
  endfunction

  logic [31:0] m_imm;
  logic [2:0]  m_type;
  logic        m_vld;
  logic [31:0] ins;
  logic        v;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.instruction = 32'h0;
    bus.valid_in = 1'b0;

    // Reset state and combinational output during reset.
    @(negedge clk);
    check_regs("reset", 32'h0, 3'd0, 1'b0);
    check_comb("in_reset", 32'h8000_0083, 32'hFFFF_F800, 3'd1);

    // Directed combinational vectors.
    check_comb("load",   32'h8000_0083, 32'hFFFF_F800, 3'd1);
    check_comb("addi",   32'h0010_0093, 32'h0000_0001, 3'd1);
    check_comb("jalr",   32'hFFF0_00E7, 32'hFFFF_FFFF, 3'd1);
    check_comb("lui",    32'h8000_00B7, 32'h8000_0000, 3'd4);
    check_comb("auipc",  32'h00F0_0097, 32'h00F0_0000, 3'd4);
    check_comb("store",  32'h8010_20A3, 32'hFFFF_F801, 3'd2);
    check_comb("branch", 32'h8010_0163, 32'hFFFF_F002, 3'd3);
    check_comb("jal",    32'h8008_10EF, 32'hFFF8_1000, 3'd5);
    check_comb("illegal",32'hFFFF_FFFE, 32'h0000_0000, 3'd0);
    check_comb("rtype",  32'h0020_81B3, 32'h0000_0000, 3'd0);
    check_comb("slli",   32'h4050_9093, 32'h0000_0405, 3'd1);

    // Release reset; first edge loads normally.
    @(negedge clk);
    rst = 1'b0;
    bus.valid_in = 1'b1;
    check_comb("pre_load", 32'h8000_0083, 32'hFFFF_F800, 3'd1);
    check_regs("pre_edge", 32'h0, 3'd0, 1'b0);
    @(posedge clk); #1;
    check_regs("first_load", 32'hFFFF_F800, 3'd1, 1'b1);

    // Hold with valid_in low.
    @(negedge clk);
    bus.valid_in = 1'b0;
    check_comb("hold_in", 32'h8000_00B7, 32'h8000_0000, 3'd4);
    @(posedge clk); #1;
    check_regs("hold", 32'hFFFF_F800, 3'd1, 1'b0);

    // Asynchronous reset mid-cycle, seen before the next edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_regs("async_rst", 32'h0, 3'd0, 1'b0);
    #2;
    rst = 1'b0;
    bus.valid_in = 1'b1;
    check_comb("post_rst_in", 32'h00F0_0097, 32'h00F0_0000, 3'd4);
    @(posedge clk); #1;
    check_regs("post_rst_load", 32'h00F0_0000, 3'd4, 1'b1);

    // Streaming then random valid pattern, all against the model.
    m_imm  = 32'h00F0_0000;
    m_type = 3'd4;
    m_vld  = 1'b1;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      ins = rand_instr();
      v   = (k < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.valid_in = v;
      check_comb("rand_comb", ins, ref_imm(ins), ref_type(ins));
      @(posedge clk); #1;
      m_vld = v;
      if (v) begin
        m_imm  = ref_imm(ins);
        m_type = ref_type(ins);
      end
      check_regs("rand_reg", m_imm, m_type, m_vld);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/imm_extender.md
Name: imm_extender

Overview:
- Immediate generator for the RV32I decode stage.
- Decodes the opcode field of a 32-bit instruction and assembles the sign-extended 32-bit immediate for the I, S, B, U and J formats.
- Provides a zero-latency combinational result for same-cycle decode and a one-cycle registered copy for the pipeline ID/EX boundary.

Parameters:
- None. Widths are fixed at 32 bits, RV32I.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RESET  input  1  asynchronous, active-high reset.
- INSTRUCTION  input  32  raw instruction word.
- VALID_IN  input  1  INSTRUCTION is valid this cycle; enables the register load.
- IMMEDIATE  output  32  combinational sign-extended immediate.
- IMM_TYPE  output  3  combinational format code: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
- IMMEDIATE_Q  output  32  registered IMMEDIATE.
- IMM_TYPE_Q  output  3  registered IMM_TYPE.
- VALID_Q  output  1  registered VALID_IN.

Behaviour:
- Format decode is combinational on INSTRUCTION[6:0]:
  - 0000011 (loads), 0010011 (OP-IMM), 1100111 (JALR) -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111 (LUI), 0010111 (AUIPC) -> U.
  - 1101111 -> J.
  - Any other opcode -> none. This includes R-type, SYSTEM, FENCE and illegal encodings.
- Immediate assembly (s = INSTRUCTION[31], replicated into all upper bits shown as s):
  - I: {20×s, INSTRUCTION[31:20]}.
  - S: {20×s, INSTRUCTION[31:25], INSTRUCTION[11:7]}.
  - B: {19×s, INSTRUCTION[31], INSTRUCTION[7], INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0}.
  - U: {INSTRUCTION[31:12], 12'b0}. No sign extension is needed.
  - J: {11×s, INSTRUCTION[31], INSTRUCTION[19:12], INSTRUCTION[20], INSTRUCTION[30:21], 1'b0}.
  - none: 32'h0000_0000.
- Special cases:
  - Shift-immediate forms (funct3 001/101 under 0010011) get no special handling. The full I immediate is produced, and the ALU uses the low 5 bits.
  - funct3, rd and rs fields never affect the result, except where they are immediate bits.
- IMMEDIATE and IMM_TYPE:
  - Purely combinational, zero latency.
  - Independent of CLK, RESET and VALID_IN.
  - No latches; every path is fully assigned.
- Registered outputs:
  - RESET high, at any time and asynchronously: IMMEDIATE_Q=0, IMM_TYPE_Q=0, VALID_Q=0 immediately, without waiting for a clock edge.
  - RESET has priority over a coincident clock edge.
  - On each rising CLK with RESET low, VALID_Q <= VALID_IN.
  - If VALID_IN=1, IMMEDIATE_Q <= IMMEDIATE and IMM_TYPE_Q <= IMM_TYPE.
  - If VALID_IN=0, IMMEDIATE_Q and IMM_TYPE_Q hold their previous values.
  - Latency is one cycle, with back-to-back throughput of one instruction per cycle.
- Deassertion of RESET:
  - The first rising edge after deassertion loads normally.
  - The combinational outputs are valid during reset.
- X handling: an unknown opcode bit may propagate X. Verification applies only known inputs.

Test Plan:
- I-type and U-type, combinational outputs (check IMMEDIATE and IMM_TYPE):
  - 32'h8000_0083 (load, imm 0x800) -> FFFFF800, type 1.
  - 32'h0010_0093 (ADDI 1) -> 00000001.
  - 32'hFFF0_00E7 (JALR −1) -> FFFFFFFF.
  - 32'h8000_00B7 (LUI) -> 80000000, type 4.
  - 32'h00F0_0097 (AUIPC) -> 00F00000.
- S-type and B-type:
  - 32'h8010_20A3 (store, imm[11:5]=1000000, imm[4:0]=00001) -> FFFFF801, type 2.
  - 32'h8010_0163 (branch, [31]=1, [11:8]=0001, [7]=0) -> FFFFF002, type 3; bit 0 is always 0.
- J-type and default:
  - 32'h8008_10EF (JAL, [19:12]=10000001) -> FFF81000, type 5.
  - 32'hFFFF_FFFE (illegal opcode) -> 00000000, type 0.
  - R-type 32'h0020_81B3 -> 00000000.
- Registered path:
  - Reset, then apply a valid instruction with VALID_IN=1: IMMEDIATE_Q is 0 before the edge and equals IMMEDIATE after one edge, with VALID_Q=1.
  - Next cycle, change INSTRUCTION with VALID_IN=0: IMMEDIATE_Q holds and VALID_Q=0.
- Asynchronous reset:
  - Assert RESET mid-cycle while IMMEDIATE_Q=FFFFF800: all registered outputs are 0 before the next CLK edge.
  - Release RESET: the next edge loads normally.
  - Streaming test: 8 different instructions back-to-back with VALID_IN=1 -> each IMMEDIATE_Q matches the prior cycle's IMMEDIATE.
